// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, Cause/Status bit positions,
// exception codes and the responder FSM state type.
package cp0_pkg;
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  localparam int BIT_IE  = 0;
  localparam int BIT_EXL = 1;
  localparam int BIT_IP2 = 10;

  typedef enum logic [1:0] {S_RUN, S_REDIRECT, S_HANDLER, S_RETURN} state_e;

  // Overflow outranks reserved-instruction, which outranks the interrupt.
  function automatic logic [4:0] exc_code(input logic ovf, input logic undef);
    if (ovf)        return EXC_OV;
    else if (undef) return EXC_RI;
    else            return EXC_INT;
  endfunction
endpackage

// File: rtl/irq_pending_latch.sv
// Rising-edge detector on the interrupt pin feeding the Cause.IP2 latch.
// A new edge in the same cycle as a clear keeps IP2 set.
module irq_pending_latch (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  input  logic clr,
  output logic ip2
);
  logic irq_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_prev <= 1'b0;
      ip2      <= 1'b0;
    end else begin
      irq_prev <= irq_in;
      if (irq_in & ~irq_prev) ip2 <= 1'b1;
      else if (clr)           ip2 <= 1'b0;
    end
  end
endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt responder: saves EPC/Cause, flushes the pipe,
// redirects fetch to the handler and back to EPC on eret.
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_in,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ovf_exc,
  input  logic        undef_exc,
  input  logic        eret,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc,
  output logic [31:0] cause,
  output logic [31:0] status
);
  state_e      state, state_nx;
  logic        ie, exl, ip2;
  logic [4:0]  code;
  logic        take, exc, wr, eret_ok, ip2_clr;

  assign take    = ex_valid & ~exl & (ovf_exc | undef_exc | (ip2 & ie));
  // Only RUN acts on a take; the redirect/return bubbles never start one.
  assign exc     = take & (state == S_RUN);
  assign wr      = ex_valid & cp0_we & ~exc;
  assign eret_ok = (state == S_HANDLER) & eret & ex_valid;
  assign ip2_clr = (exc & ~ovf_exc & ~undef_exc)
                 | (wr & (cp0_addr == REG_CAUSE) & ~cp0_wdata[BIT_IP2]);

  irq_pending_latch u_irq (
    .clk    (clk),
    .rst    (rst),
    .irq_in (irq_in),
    .clr    (ip2_clr),
    .ip2    (ip2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie   <= 1'b1;
      exl  <= 1'b0;
      code <= EXC_INT;
      epc  <= 32'h0;
    end else if (exc) begin
      epc  <= ex_pc;
      code <= exc_code(ovf_exc, undef_exc);
      exl  <= 1'b1;
    end else begin
      if (wr) begin
        case (cp0_addr)
          REG_STATUS: begin
            ie  <= cp0_wdata[BIT_IE];
            exl <= cp0_wdata[BIT_EXL];
          end
          REG_CAUSE: code <= cp0_wdata[6:2];
          REG_EPC:   epc  <= cp0_wdata;
          default: ;
        endcase
      end
      if (eret_ok) exl <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RUN;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = 32'h0;
    case (state)
      S_RUN: begin
        if (take) begin
          flush_if = 1'b1;
          flush_id = 1'b1;
          flush_ex = 1'b1;
          state_nx = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        pc_redirect = 1'b1;
        redirect_pc = HANDLER_ADDR;
        flush_if    = 1'b1;
        state_nx    = S_HANDLER;
      end
      S_HANDLER: begin
        if (eret_ok) begin
          flush_if = 1'b1;
          flush_id = 1'b1;
          state_nx = S_RETURN;
        end
      end
      S_RETURN: begin
        pc_redirect = 1'b1;
        redirect_pc = epc;
        flush_if    = 1'b1;
        state_nx    = S_RUN;
      end
      default: state_nx = S_RUN;
    endcase
  end

  assign status = {30'h0, exl, ie};
  assign cause  = {21'h0, ip2, 3'h0, code, 2'h0};

  always_comb begin
    cp0_rdata = 32'h0;
    case (cp0_addr)
      REG_STATUS: cp0_rdata = status;
      REG_CAUSE:  cp0_rdata = cause;
      REG_EPC:    cp0_rdata = epc;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cp0_exc_unit.sv
// Bench for cp0_exc_unit: directed scenarios plus a randomized run checked
// against a behavioural model of the CP0 registers and pipeline phase.
module tb_cp0_exc_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        irq_in, ex_valid, ovf_exc, undef_exc, eret, cp0_we;
  logic [31:0] ex_pc, cp0_wdata;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_rdata, redirect_pc, epc, cause, status;
  logic        flush_if, flush_id, flush_ex, pc_redirect;

  int n_cmp = 0;
  int n_err = 0;

  // model: mode 0 run, 1 redirect, 2 handler, 3 return
  int          m_mode;
  logic        m_ie, m_exl, m_ip2, m_prev;
  logic [4:0]  m_code;
  logic [31:0] m_epc;
  logic        e_take, e_fif, e_fid, e_fex, e_red;
  logic [31:0] e_rpc, e_rdata, e_status, e_cause;

  always #5 clk = ~clk;

  cp0_exc_unit dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ovf_exc(ovf_exc), .undef_exc(undef_exc), .eret(eret), .cp0_we(cp0_we),
    .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
    .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .epc(epc), .cause(cause), .status(status)
  );

  task automatic model_reset();
    m_mode = 0; m_ie = 1'b1; m_exl = 1'b0; m_ip2 = 1'b0; m_prev = 1'b0;
    m_code = 5'd0; m_epc = 32'h0;
  endtask

  task automatic to_neg();
    @(negedge clk);
    irq_in = 0; ex_valid = 0; ovf_exc = 0; undef_exc = 0; eret = 0; cp0_we = 0;
    ex_pc = 32'h0; cp0_addr = 5'd0; cp0_wdata = 32'h0;
  endtask

  // Expected combinational outputs from the model for the current inputs.
  task automatic settle();
    #1;
    e_status = 32'h0; e_status[0] = m_ie; e_status[1] = m_exl;
    e_cause = 32'h0; e_cause[10] = m_ip2; e_cause[6:2] = m_code;
    e_take = (m_mode == 0) && ex_valid && !m_exl && (ovf_exc || undef_exc || (m_ip2 && m_ie));
    e_fif = 0; e_fid = 0; e_fex = 0; e_red = 0; e_rpc = 32'h0;
    if (e_take) begin e_fif = 1; e_fid = 1; e_fex = 1; end
    if (m_mode == 1) begin e_red = 1; e_rpc = 32'h80; e_fif = 1; end
    if (m_mode == 2 && eret && ex_valid) begin e_fif = 1; e_fid = 1; end
    if (m_mode == 3) begin e_red = 1; e_rpc = m_epc; e_fif = 1; end
    e_rdata = (cp0_addr == 5'd12) ? e_status : (cp0_addr == 5'd13) ? e_cause :
              (cp0_addr == 5'd14) ? m_epc : 32'h0;
  endtask

  task automatic tick();
    logic set, clr;
    @(posedge clk);
    set = irq_in && !m_prev; clr = 0; m_prev = irq_in;
    if (e_take) begin
      m_epc = ex_pc;
      m_code = ovf_exc ? 5'd12 : (undef_exc ? 5'd10 : 5'd0);
      m_exl = 1; clr = (m_code == 5'd0); m_mode = 1;
    end else begin
      if (ex_valid && cp0_we) begin
        if (cp0_addr == 5'd12) begin m_ie = cp0_wdata[0]; m_exl = cp0_wdata[1]; end
        if (cp0_addr == 5'd13) begin m_code = cp0_wdata[6:2]; clr = !cp0_wdata[10]; end
        if (cp0_addr == 5'd14) m_epc = cp0_wdata;
      end
      if (m_mode == 1) m_mode = 2;
      else if (m_mode == 2 && eret && ex_valid) begin m_exl = 0; m_mode = 3; end
      else if (m_mode == 3) m_mode = 0;
    end
    m_ip2 = set ? 1'b1 : (clr ? 1'b0 : m_ip2);
  endtask

  // From HANDLER: eret cycle then the return-redirect cycle.
  task automatic ret_seq();
    to_neg(); ex_valid = 1; eret = 1; settle(); tick();
    to_neg(); settle(); tick();
  endtask

  task automatic test_reset();
    rst = 0; model_reset();
    irq_in = 0; ex_valid = 0; ovf_exc = 0; undef_exc = 0; eret = 0; cp0_we = 0;
    ex_pc = 0; cp0_addr = 0; cp0_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1;
    to_neg(); settle();
    n_cmp++; if (status !== 32'h1) begin n_err++; $display("FAIL reset_status: got %h want 1", status); end
    n_cmp++; if (cause !== 32'h0) begin n_err++; $display("FAIL reset_cause: got %h want 0", cause); end
    n_cmp++; if (epc !== 32'h0) begin n_err++; $display("FAIL reset_epc: got %h want 0", epc); end
    n_cmp++; if ({pc_redirect, redirect_pc} !== 33'h0) begin n_err++; $display("FAIL reset_redirect: got %b/%h want 0/0", pc_redirect, redirect_pc); end
    n_cmp++; if ({flush_if, flush_id, flush_ex} !== 3'b000) begin n_err++; $display("FAIL reset_flush: got %b want 000", {flush_if, flush_id, flush_ex}); end
    tick();
  endtask

  task automatic test_irq_take();
    to_neg(); irq_in = 1; ex_valid = 1; ex_pc = 32'h40; settle();
    n_cmp++; if (flush_ex !== 1'b0) begin n_err++; $display("FAIL irq_early_take: got %b want 0", flush_ex); end
    tick();
    to_neg(); ex_valid = 1; ex_pc = 32'h40; settle();
    n_cmp++; if ({flush_if, flush_id, flush_ex} !== 3'b111) begin n_err++; $display("FAIL irq_flush: got %b want 111", {flush_if, flush_id, flush_ex}); end
    tick();
    to_neg(); settle();
    n_cmp++; if ({pc_redirect, redirect_pc} !== {1'b1, 32'h80}) begin n_err++; $display("FAIL irq_redirect: got %b/%h want 1/80", pc_redirect, redirect_pc); end
    n_cmp++; if (epc !== 32'h40) begin n_err++; $display("FAIL irq_epc: got %h want 40", epc); end
    n_cmp++; if ({cause[10], cause[6:2], status[1]} !== 7'b0_00000_1) begin n_err++; $display("FAIL irq_cause: got ip2=%b code=%0d exl=%b want 0/0/1", cause[10], cause[6:2], status[1]); end
    tick();
    to_neg(); ex_valid = 1; eret = 1; settle();
    n_cmp++; if ({flush_if, flush_id, flush_ex} !== 3'b110) begin n_err++; $display("FAIL eret_flush: got %b want 110", {flush_if, flush_id, flush_ex}); end
    tick();
    to_neg(); settle();
    n_cmp++; if ({pc_redirect, redirect_pc, status[1]} !== {1'b1, 32'h40, 1'b0}) begin n_err++; $display("FAIL eret_return: got %b/%h exl=%b want 1/40/0", pc_redirect, redirect_pc, status[1]); end
    tick();
  endtask

  task automatic test_priority();
    to_neg(); irq_in = 1; settle(); tick();
    to_neg(); ex_valid = 1; ovf_exc = 1; undef_exc = 1; ex_pc = 32'h1C; settle();
    n_cmp++; if (flush_ex !== 1'b1) begin n_err++; $display("FAIL prio_take: got %b want 1", flush_ex); end
    tick();
    to_neg(); settle();
    n_cmp++; if ({epc, cause[6:2], cause[10]} !== {32'h1C, 5'd12, 1'b1}) begin n_err++; $display("FAIL prio_regs: got epc=%h code=%0d ip2=%b want 1c/12/1", epc, cause[6:2], cause[10]); end
    tick();
    to_neg(); irq_in = 1; ex_valid = 1; ovf_exc = 1; ex_pc = 32'h200; settle();
    n_cmp++; if ({flush_if, flush_ex} !== 2'b00) begin n_err++; $display("FAIL handler_masked: got %b want 00", {flush_if, flush_ex}); end
    tick();
    to_neg(); ex_valid = 1; eret = 1; settle();
    n_cmp++; if (cause[10] !== 1'b1) begin n_err++; $display("FAIL handler_ip2: got %b want 1", cause[10]); end
    tick();
    to_neg(); settle();
    n_cmp++; if (redirect_pc !== 32'h1C) begin n_err++; $display("FAIL prio_return: got %h want 1c", redirect_pc); end
    tick();
    to_neg(); settle();
    n_cmp++; if (flush_ex !== 1'b0) begin n_err++; $display("FAIL bubble_no_take: got %b want 0", flush_ex); end
    tick();
    to_neg(); ex_valid = 1; ex_pc = 32'h24; settle();
    n_cmp++; if (flush_ex !== 1'b1) begin n_err++; $display("FAIL pending_take: got %b want 1", flush_ex); end
    tick();
    to_neg(); settle();
    n_cmp++; if ({epc, cause[6:2], cause[10]} !== {32'h24, 5'd0, 1'b0}) begin n_err++; $display("FAIL pending_regs: got epc=%h code=%0d ip2=%b want 24/0/0", epc, cause[6:2], cause[10]); end
    tick();
    ret_seq();
  endtask

  task automatic test_mask();
    to_neg(); ex_valid = 1; cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0; settle();
    n_cmp++; if (cp0_rdata !== 32'h1) begin n_err++; $display("FAIL mfc0_no_bypass: got %h want 1", cp0_rdata); end
    tick();
    to_neg(); irq_in = 1; ex_valid = 1; settle(); tick();
    to_neg(); ex_valid = 1; cp0_addr = 5'd12; settle();
    n_cmp++; if ({flush_ex, cause[10], cp0_rdata} !== {1'b0, 1'b1, 32'h0}) begin n_err++; $display("FAIL mask_ie: got take=%b ip2=%b st=%h want 0/1/0", flush_ex, cause[10], cp0_rdata); end
    tick();
    to_neg(); ex_valid = 1; cp0_we = 1; cp0_addr = 5'd13; cp0_wdata = 32'h0; settle(); tick();
    to_neg(); cp0_addr = 5'd13; settle();
    n_cmp++; if ({cp0_rdata, cause} !== 64'h0) begin n_err++; $display("FAIL mtc0_cause_clr: got %h/%h want 0/0", cp0_rdata, cause); end
    tick();
    to_neg(); ex_valid = 1; cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h1; settle(); tick();
  endtask

  task automatic test_hold();
    int takes = 0;
    for (int i = 0; i < 5; i++) begin
      to_neg(); irq_in = 1; ex_valid = 1; ex_pc = 32'h100; settle();
      if (flush_ex === 1'b1) takes++;
      tick();
    end
    ret_seq();
    for (int i = 0; i < 3; i++) begin
      to_neg(); ex_valid = 1; ex_pc = 32'h104; settle();
      if (flush_ex === 1'b1) takes++;
      tick();
    end
    n_cmp++; if (takes !== 1) begin n_err++; $display("FAIL hold_one_take: got %0d want 1", takes); end
  endtask

  task automatic test_async_reset();
    to_neg(); ex_valid = 1; ovf_exc = 1; ex_pc = 32'h300; settle(); tick();
    to_neg(); settle();
    n_cmp++; if (pc_redirect !== 1'b1) begin n_err++; $display("FAIL ar_in_redirect: got %b want 1", pc_redirect); end
    #2 rst = 0; model_reset();
    #1;
    n_cmp++; if ({pc_redirect, status, epc} !== {1'b0, 32'h1, 32'h0}) begin n_err++; $display("FAIL ar_immediate: got %b/%h/%h want 0/1/0", pc_redirect, status, epc); end
    @(negedge clk); rst = 1;
    to_neg(); ex_valid = 1; undef_exc = 1; ex_pc = 32'h44; settle();
    n_cmp++; if (flush_ex !== 1'b1) begin n_err++; $display("FAIL ar_state_run: got %b want 1", flush_ex); end
    tick();
    to_neg(); settle();
    n_cmp++; if ({redirect_pc, cause[6:2]} !== {32'h80, 5'd10}) begin n_err++; $display("FAIL ar_retake: got %h/%0d want 80/10", redirect_pc, cause[6:2]); end
    tick();
    ret_seq();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      to_neg();
      ex_valid  = (m_mode == 1 || m_mode == 3) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
      ex_pc     = $urandom & 32'hFFFF_FFFC;
      irq_in    = ($urandom_range(0, 3) == 0);
      ovf_exc   = ($urandom_range(0, 9) == 0);
      undef_exc = ($urandom_range(0, 9) == 0);
      cp0_we    = ($urandom_range(0, 5) == 0);
      eret      = !cp0_we && ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: cp0_addr = 5'd12;
        1: cp0_addr = 5'd13;
        2: cp0_addr = 5'd14;
        default: cp0_addr = 5'd3;
      endcase
      cp0_wdata = $urandom;
      if (cp0_addr == 5'd12) cp0_wdata[1] = ($urandom_range(0, 3) == 0);
      settle();
      n_cmp++; if ({flush_if, flush_id, flush_ex} !== {e_fif, e_fid, e_fex}) begin n_err++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, {flush_if, flush_id, flush_ex}, {e_fif, e_fid, e_fex}); end
      n_cmp++; if ({pc_redirect, redirect_pc} !== {e_red, e_rpc}) begin n_err++; $display("FAIL rnd_redirect[%0d]: got %b/%h want %b/%h", i, pc_redirect, redirect_pc, e_red, e_rpc); end
      n_cmp++; if (cp0_rdata !== e_rdata) begin n_err++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, cp0_rdata, e_rdata); end
      n_cmp++; if ({epc, cause, status} !== {m_epc, e_cause, e_status}) begin n_err++; $display("FAIL rnd_regs[%0d]: got %h/%h/%h want %h/%h/%h", i, epc, cause, status, m_epc, e_cause, e_status); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_irq_take();
    test_priority();
    test_mask();
    test_hold();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
